prio_enc_rr: RTL

PRIO_ENC_RR -- requirements
Module: prio_enc_rr

---
 rtl/prio_enc_rr_pkg.sv | 16 +
 rtl/prio_enc_rr_pick.sv | 49 ++++
 rtl/prio_enc_rr.sv | 104 ++++++++++
 3 files changed

// File: rtl/prio_enc_rr_pkg.sv
// Shared types and constants for the prio_enc_rr priority encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package prio_enc_rr_pkg;

  // Encoder FSM: IDLE waits for a request, HOLD presents idx until accepted.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Selection policy encodings for the MODE parameter.
  localparam int FIXED = 0;
  localparam int RR    = 1;

endpackage

// File: rtl/prio_enc_rr_pick.sv
// Combinational request picker: lowest set bit at/above a start point, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample index/found.
module prio_pick #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  int         start_i;
  logic       hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Search from the start point upward; if nothing there, wrap to the lowest set bit.
  always_comb begin
    start_i  = 0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    found    = 1'b0;
    index    = '0;

    // Fixed priority always starts at bit 0; an out-of-range pointer is treated as 0.
    if (mode && (int'(ptr) < WIDTH)) begin
      start_i = int'(ptr);
    end

    // Scanning downward leaves the lowest qualifying bit as the final assignment.
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IDX_W'(j);
        found  = 1'b1;
        if (j >= start_i) begin
          hi_idx   = IDX_W'(j);
          hi_found = 1'b1;
        end
      end
    end

    index = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Priority encoder (fixed or round-robin) presenting one registered index per grant.
// Latency: 1 cycle from request sampled in IDLE to valid/idx.
// Backpressure: idx/valid held stable while ready is low; one accept every 2 cycles max.
module prio_enc_rr
  import prio_enc_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] req,
  input  logic             ready,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             none
);

  localparam logic MODE_IS_RR = (MODE == RR);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             valid_q, valid_d;
  logic             none_q,  none_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  prio_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mode  (MODE_IS_RR),
    .index (pick_idx),
    .found (pick_found)
  );

  // Next-state and next-output computation for the IDLE/HOLD handshake machine.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    none_d  = 1'b0;
    ptr_d   = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (!enable) begin
          idx_d   = '0;
          valid_d = 1'b0;
        end else if (pick_found) begin
          idx_d   = pick_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          none_d  = 1'b1;
        end
      end
      HOLD: begin
        // The held index survives req/enable changes; only the handshake releases it.
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (MODE_IS_RR) begin
            ptr_d = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            ptr_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      none_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      ptr_q   <= ptr_d;
    end
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign none  = none_q;

endmodule
